apb_uart_cmd_master: RTL and testbench

- Byte-stream-to-APB initiator. Decodes simple command frames arriving from a UART receiver's byte interface.
- Issues the matching APB3 read or write to a CoreUARTapb-style 8-bit slave, then returns one response byte on a UART transmitter's byte interface.
- It is the initiator end of the APB link whose responder side the UART cores implement. It lets a host drive the register map over a serial line with no CPU on chip.

---
 rtl/apb_uart_cmd_master_if.sv | 29 ++
 rtl/apb_uart_cmd_master.sv | 195 +++++++++++++++++++
 tb/tb_apb_uart_cmd_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_cmd_master_if.sv
// Byte-stream and APB3 signal bundle for the UART command master.
// The master modport is the initiator view; slave is the UART/APB peer side.
interface apb_uart_cmd_master_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [7:0]        RX_DATA;
  logic              RX_VALID;
  logic [7:0]        TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [7:0]        PWDATA;
  logic [7:0]        PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  RX_DATA, RX_VALID, TX_READY, PRDATA, PREADY, PSLVERR,
    output TX_DATA, TX_VALID, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output RX_DATA, RX_VALID, TX_READY, PRDATA, PREADY, PSLVERR,
    input  TX_DATA, TX_VALID, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_uart_cmd_master.sv
// Decodes 'W addr data' / 'R addr' byte frames into one APB3 transfer and
// answers with a single response byte (read data, write ack or error code).
module apb_uart_cmd_master #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  WR_ACK   = 8'h4B,
  parameter logic [7:0]  ERR_CODE = 8'h45
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  apb_uart_cmd_master_if.master bus,
  output logic                  BUSY,
  output logic                  ERR
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    SETUP    = 3'd3,
    ACCESS   = 3'd4,
    RESP     = 3'd5
  } state_e;

  localparam logic [7:0]  OP_WR    = 8'h57;
  localparam logic [7:0]  OP_RD    = 8'h52;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [7:0]        pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [15:0]       cnt_q, cnt_d;

  // Next-state and registered-output computation for the frame/APB sequencer.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.RX_VALID) begin
          if (bus.RX_DATA == OP_WR) begin
            wr_d    = 1'b1;
            state_d = GET_ADDR;
          end else if (bus.RX_DATA == OP_RD) begin
            wr_d    = 1'b0;
            state_d = GET_ADDR;
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      GET_ADDR: begin
        if (bus.RX_VALID) begin
          paddr_d = bus.RX_DATA[ADDR_W-1:0];
          if (wr_q) begin
            state_d = GET_DATA;
          end else begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            pwrite_d = 1'b0;
            cnt_d    = 16'd0;
          end
        end else begin
          state_d = GET_ADDR;
        end
      end

      GET_DATA: begin
        if (bus.RX_VALID) begin
          pwdata_d = bus.RX_DATA;
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = wr_q;
          cnt_d    = 16'd0;
        end else begin
          state_d = GET_DATA;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      // Completion and timeout both close the transfer and queue a response.
      ACCESS: begin
        if (bus.PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = RESP;
          if (bus.PSLVERR) begin
            tx_data_d = ERR_CODE;
            err_d     = 1'b1;
          end else if (pwrite_q) begin
            tx_data_d = WR_ACK;
          end else begin
            tx_data_d = bus.PRDATA;
          end
        end else if (cnt_q == TMO_LAST) begin
          cnt_d     = cnt_q + 16'd1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          tx_data_d = ERR_CODE;
          err_d     = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RESP: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
        end else if (bus.TX_READY) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          tx_valid_d = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        psel_d     = 1'b0;
        penable_d  = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= 8'h00;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.PADDR    = paddr_q;
  assign bus.PWDATA   = pwdata_q;
  assign bus.PSEL     = psel_q;
  assign bus.PENABLE  = penable_q;
  assign bus.PWRITE   = pwrite_q;
  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_VALID = tx_valid_q;
  assign BUSY         = busy_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_apb_uart_cmd_master.sv
// Directed bench for apb_uart_cmd_master: frames driven byte by byte, APB
// slave responses driven by hand, outputs sampled 1ns after each rising edge.
module tb_apb_uart_cmd_master;

  logic PCLK;
  logic PRESETN;
  logic BUSY;
  logic ERR;
  int   n_tests;
  int   n_fail;
  int   err_cnt;
  int   err_base;

  apb_uart_cmd_master_if #(.ADDR_W(5)) bus ();

  apb_uart_cmd_master #(
    .ADDR_W  (5),
    .TIMEOUT (8),
    .WR_ACK  (8'h4B),
    .ERR_CODE(8'h45)
  ) dut (
    .PCLK   (PCLK),
    .PRESETN(PRESETN),
    .bus    (bus),
    .BUSY   (BUSY),
    .ERR    (ERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ERR pulse counter, sampled mid-cycle.
  always @(negedge PCLK) begin
    if (ERR === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    step();
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'h00;
  endtask

  task automatic handshake();
    bus.TX_READY = 1'b1;
    step();
    bus.TX_READY = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    err_cnt = 0;
    PRESETN      = 1'b0;
    bus.RX_DATA  = 8'h00;
    bus.RX_VALID = 1'b0;
    bus.TX_READY = 1'b0;
    bus.PRDATA   = 8'h00;
    bus.PREADY   = 1'b1;
    bus.PSLVERR  = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst_psel",    32'(bus.PSEL),     32'h0);
    chk("rst_penable", 32'(bus.PENABLE),  32'h0);
    chk("rst_pwrite",  32'(bus.PWRITE),   32'h0);
    chk("rst_paddr",   32'(bus.PADDR),    32'h0);
    chk("rst_pwdata",  32'(bus.PWDATA),   32'h0);
    chk("rst_txvalid", 32'(bus.TX_VALID), 32'h0);
    chk("rst_txdata",  32'(bus.TX_DATA),  32'h0);
    chk("rst_busy",    32'(BUSY),         32'h0);
    chk("rst_err",     32'(ERR),          32'h0);
    PRESETN = 1'b1;
    step();

    // Write 57,03,A5 with zero wait states
    send_byte(8'h57);
    chk("wr_busy_addr", 32'(BUSY), 32'h1);
    send_byte(8'h03);
    send_byte(8'hA5);
    chk("wr_setup_psel",    32'(bus.PSEL),    32'h1);
    chk("wr_setup_penable", 32'(bus.PENABLE), 32'h0);
    chk("wr_setup_pwrite",  32'(bus.PWRITE),  32'h1);
    chk("wr_setup_paddr",   32'(bus.PADDR),   32'h03);
    chk("wr_setup_pwdata",  32'(bus.PWDATA),  32'hA5);
    step();
    chk("wr_access_psel",    32'(bus.PSEL),    32'h1);
    chk("wr_access_penable", 32'(bus.PENABLE), 32'h1);
    chk("wr_access_paddr",   32'(bus.PADDR),   32'h03);
    chk("wr_access_pwdata",  32'(bus.PWDATA),  32'hA5);
    step();
    chk("wr_done_psel",    32'(bus.PSEL),     32'h0);
    chk("wr_done_penable", 32'(bus.PENABLE),  32'h0);
    chk("wr_n2_txvalid",   32'(bus.TX_VALID), 32'h0);
    step();
    chk("wr_n3_txvalid", 32'(bus.TX_VALID), 32'h1);
    chk("wr_n3_txdata",  32'(bus.TX_DATA),  32'h4B);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wr_hold_txvalid", 32'(bus.TX_VALID), 32'h1);
    end
    handshake();
    chk("wr_end_txvalid", 32'(bus.TX_VALID), 32'h0);
    chk("wr_end_busy",    32'(BUSY),         32'h0);

    // Read 52,04 with two wait states
    send_byte(8'h52);
    bus.PREADY = 1'b0;
    send_byte(8'h04);
    chk("rd_setup_psel",   32'(bus.PSEL),   32'h1);
    chk("rd_setup_pwrite", 32'(bus.PWRITE), 32'h0);
    chk("rd_setup_paddr",  32'(bus.PADDR),  32'h04);
    step();
    chk("rd_acc1_penable", 32'(bus.PENABLE), 32'h1);
    step();
    chk("rd_acc2_penable", 32'(bus.PENABLE), 32'h1);
    step();
    chk("rd_acc3_penable", 32'(bus.PENABLE), 32'h1);
    chk("rd_acc3_psel",    32'(bus.PSEL),    32'h1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h5C;
    step();
    bus.PRDATA = 8'h00;
    chk("rd_n4_psel",    32'(bus.PSEL),     32'h0);
    chk("rd_n4_txvalid", 32'(bus.TX_VALID), 32'h0);
    step();
    chk("rd_n5_txvalid", 32'(bus.TX_VALID), 32'h1);
    chk("rd_n5_txdata",  32'(bus.TX_DATA),  32'h5C);
    handshake();
    chk("rd_end_busy", 32'(BUSY), 32'h0);

    // Timeout after 8 wait cycles
    err_base = err_cnt;
    bus.PREADY = 1'b0;
    send_byte(8'h52);
    send_byte(8'h07);
    step();
    for (int i = 0; i < 7; i++) step();
    chk("tmo_w7_psel",    32'(bus.PSEL),    32'h1);
    chk("tmo_w7_penable", 32'(bus.PENABLE), 32'h1);
    chk("tmo_w7_err",     32'(ERR),         32'h0);
    step();
    chk("tmo_abort_psel",    32'(bus.PSEL),    32'h0);
    chk("tmo_abort_penable", 32'(bus.PENABLE), 32'h0);
    chk("tmo_abort_err",     32'(ERR),         32'h1);
    step();
    chk("tmo_err_clear", 32'(ERR),          32'h0);
    chk("tmo_txvalid",   32'(bus.TX_VALID), 32'h1);
    chk("tmo_txdata",    32'(bus.TX_DATA),  32'h45);
    handshake();
    chk("tmo_err_once", 32'(err_cnt - err_base), 32'h1);
    chk("tmo_idle",     32'(BUSY),               32'h0);
    bus.PREADY = 1'b1;
    send_byte(8'h57);
    send_byte(8'h02);
    send_byte(8'h11);
    step(); step(); step();
    chk("tmo_next_txvalid", 32'(bus.TX_VALID), 32'h1);
    chk("tmo_next_txdata",  32'(bus.TX_DATA),  32'h4B);
    chk("tmo_next_paddr",   32'(bus.PADDR),    32'h02);
    handshake();

    // PSLVERR on write completion
    err_base = err_cnt;
    bus.PSLVERR = 1'b1;
    send_byte(8'h57);
    send_byte(8'h05);
    send_byte(8'h3C);
    step();
    step();
    bus.PSLVERR = 1'b0;
    chk("slverr_psel",    32'(bus.PSEL),    32'h0);
    chk("slverr_penable", 32'(bus.PENABLE), 32'h0);
    chk("slverr_err",     32'(ERR),         32'h1);
    step();
    chk("slverr_txvalid", 32'(bus.TX_VALID), 32'h1);
    chk("slverr_txdata",  32'(bus.TX_DATA),  32'h45);
    handshake();
    chk("slverr_err_once", 32'(err_cnt - err_base), 32'h1);

    // Bad opcode, then a read with a byte injected during ACCESS
    err_base = err_cnt;
    send_byte(8'h33);
    chk("bad_err",  32'(ERR),      32'h1);
    chk("bad_busy", 32'(BUSY),     32'h0);
    chk("bad_psel", 32'(bus.PSEL), 32'h0);
    step();
    chk("bad_err_clear", 32'(ERR),      32'h0);
    chk("bad_psel2",     32'(bus.PSEL), 32'h0);
    bus.PREADY = 1'b0;
    send_byte(8'h52);
    send_byte(8'h01);
    step();
    send_byte(8'h57);
    chk("inj_penable", 32'(bus.PENABLE), 32'h1);
    chk("inj_paddr",   32'(bus.PADDR),   32'h01);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h9E;
    step();
    bus.PRDATA = 8'h00;
    step();
    chk("inj_txvalid", 32'(bus.TX_VALID), 32'h1);
    chk("inj_txdata",  32'(bus.TX_DATA),  32'h9E);
    handshake();
    step();
    chk("inj_idle",     32'(BUSY),               32'h0);
    chk("inj_err_once", 32'(err_cnt - err_base), 32'h1);

    // Reset during ACCESS
    bus.PREADY = 1'b0;
    send_byte(8'h57);
    send_byte(8'h06);
    send_byte(8'h77);
    step();
    chk("mid_penable", 32'(bus.PENABLE), 32'h1);
    PRESETN = 1'b0;
    step();
    chk("mid_rst_psel",    32'(bus.PSEL),     32'h0);
    chk("mid_rst_penable", 32'(bus.PENABLE),  32'h0);
    chk("mid_rst_pwrite",  32'(bus.PWRITE),   32'h0);
    chk("mid_rst_paddr",   32'(bus.PADDR),    32'h0);
    chk("mid_rst_pwdata",  32'(bus.PWDATA),   32'h0);
    chk("mid_rst_txdata",  32'(bus.TX_DATA),  32'h0);
    chk("mid_rst_txvalid", 32'(bus.TX_VALID), 32'h0);
    chk("mid_rst_busy",    32'(BUSY),         32'h0);
    PRESETN = 1'b1;
    bus.PREADY = 1'b1;
    step(); step(); step();
    chk("mid_no_tx", 32'(bus.TX_VALID), 32'h0);

    // Subsequent frame with TX_READY held low for 10 cycles
    send_byte(8'h57);
    send_byte(8'h08);
    send_byte(8'hC3);
    chk("post_pwdata", 32'(bus.PWDATA), 32'hC3);
    step(); step(); step();
    chk("post_txvalid", 32'(bus.TX_VALID), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_txvalid", 32'(bus.TX_VALID), 32'h1);
      chk("hold_txdata",  32'(bus.TX_DATA),  32'h4B);
    end
    handshake();
    chk("post_txvalid_drop", 32'(bus.TX_VALID), 32'h0);
    chk("post_busy",         32'(BUSY),         32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
